// File: rtl/add_sched_pkg.sv
// ----------------------------------------------------------------------------
// add_sched_pkg
//   Shared definitions for the add_sched shared-adder scheduler:
//     - state_e     : scheduler FSM states (IDLE / ADD / HOLD)
//     - NREQ_DEF    : default number of requesters
//     - WIDTH_DEF   : default operand width
//     - clog2()     : constant-evaluable ceiling log2, used to size IDs
// ----------------------------------------------------------------------------
package add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 4;

    // Ceiling log2; returns at least 1 so a 1-bit ID exists for NREQ=2.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/add_sched_arb.sv
// ----------------------------------------------------------------------------
// add_sched_arb
//   Combinational requester picker for add_sched.
//   Build option: ADD_SCHED_PRIO_EN
//     undefined (default) : round-robin, search starts at last_grant_i+1 and
//                           wraps NREQ-1 -> 0; first valid requester wins.
//     defined             : fixed priority, lowest valid index always wins;
//                           last_grant_i is ignored.
//   Ports:
//     req_valid_i  [NREQ-1:0]  per-requester valid
//     last_grant_i [IDW-1:0]   index of the most recent grant
//     grant_o      [NREQ-1:0]  one-hot winner (all zero when nobody is valid)
//     grant_idx_o  [IDW-1:0]   binary index of the winner (0 when none)
//     grant_vld_o              a winner exists
// ----------------------------------------------------------------------------
module add_sched_arb
    import add_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            grant_vld_o
);

    logic [IDW-1:0] idx;
    logic           found;

`ifdef ADD_SCHED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant_i;

    always_comb begin
        found       = 1'b0;
        grant_idx_o = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid_i[idx]) begin
                found       = 1'b1;
                grant_idx_o = idx;
            end
            idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
        end
    end
`else
    // Walk the ring starting one past the last winner; the last winner is
    // visited last, which gives it lowest priority this round.
    always_comb begin
        found       = 1'b0;
        grant_idx_o = '0;
        idx         = last_grant_i;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
            if (!found && req_valid_i[idx]) begin
                found       = 1'b1;
                grant_idx_o = idx;
            end
        end
    end
`endif

    assign grant_vld_o = found;
    assign grant_o     = found ? (NREQ'(1) << grant_idx_o) : '0;

endmodule

// File: rtl/add_sched.sv
// ----------------------------------------------------------------------------
// add_sched
//   Shares one WIDTH-bit adder among NREQ requesters. The arbitration winner's
//   operands are latched on the grant edge, added in ADD, and the WIDTH+1 bit
//   sum (carry-out kept) is held with the winner's ID until rsp_ready.
//   FSM: IDLE -> ADD -> HOLD -> IDLE.
//   Build option: ADD_SCHED_PRIO_EN (fixed priority instead of round-robin,
//   selected inside add_sched_arb).
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     req_valid  [NREQ-1:0]        per-requester operand valid
//     req_ready  [NREQ-1:0]        one-hot accept, only in IDLE
//     req_a      [NREQ*WIDTH-1:0]  operand a, requester i at [i*WIDTH +: WIDTH]
//     req_b      [NREQ*WIDTH-1:0]  operand b, same packing
//     rsp_valid                    result valid
//     rsp_ready                    consumer accepts result
//     rsp_id     [IDW-1:0]         owner of rsp_sum
//     rsp_sum    [WIDTH:0]         a+b, bit WIDTH = carry-out
//     busy                         high outside IDLE
// ----------------------------------------------------------------------------
module add_sched
    import add_sched_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDW   = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    output logic                  busy
);

    state_e         state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [WIDTH:0] rsp_sum_q, rsp_sum_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_vld;
    logic [WIDTH-1:0] a_sel, b_sel;

    add_sched_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .grant_vld_o  (grant_vld)
    );

    // One-hot operand mux driven by the arbiter's grant vector.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    a_d          = a_sel;
                    b_d          = b_sel;
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ADD;
                end
            end
            ADD: begin
                rsp_sum_d   = {1'b0, a_q} + {1'b0, b_q};
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
        end
    end

    // Ready is suppressed while reset is asserted so no accept is advertised.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_sched.sv
// ----------------------------------------------------------------------------
// tb_add_sched
//   Directed self-checking bench for add_sched (NREQ=4, WIDTH=4).
//   Expected grant orders follow ADD_SCHED_PRIO_EN when that macro is defined.
// ----------------------------------------------------------------------------
module tb_add_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH:0]        rsp_sum;
    logic                  busy;

    int n_assert = 0;
    int n_fail   = 0;

    add_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return 1 time unit later so registered
    // outputs are settled and input changes are far from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer vmask with packed operands, expect requester exp_id to win.
    // Operands are corrupted right after the grant edge to confirm they
    // are sampled only on that edge. Leaves the DUT in HOLD.
    task automatic grant_op(input string tag, input logic [3:0] vmask,
                            input logic [15:0] a_all, input logic [15:0] b_all,
                            input int unsigned exp_id);
        logic [3:0] ea, eb;
        logic [4:0] esum;
        ea   = a_all[exp_id*4 +: 4];
        eb   = b_all[exp_id*4 +: 4];
        esum = {1'b0, ea} + {1'b0, eb};
        req_valid = vmask;
        req_a     = a_all;
        req_b     = b_all;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(4'b0001 << exp_id));
        tick();
        req_a = ~a_all;
        req_b = ~b_all;
        #1;
        chk({tag, ".add_busy"},  32'(busy), 32'd1);
        chk({tag, ".add_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".add_rspv"},  32'(rsp_valid), 32'd0);
        tick();
        chk({tag, ".rspv"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".id"},   32'(rsp_id), exp_id);
        chk({tag, ".sum"},  32'(rsp_sum), 32'(esum));
    endtask

    // Accept the response; expect return to IDLE with result retained.
    task automatic release_op(input string tag, input logic [4:0] held_sum);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ".rel_rspv"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rel_busy"}, 32'(busy), 32'd0);
        chk({tag, ".rel_sum"},  32'(rsp_sum), 32'(held_sum));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] va, vb;
        logic [4:0]  s;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 16'h1234;
        req_b     = 16'h5678;
        rsp_ready = 1'b0;

        // 1: reset with all requesters valid
        tick(); tick(); tick();
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.rspv",  32'(rsp_valid), 32'd0);
        chk("rst.id",    32'(rsp_id),    32'd0);
        chk("rst.sum",   32'(rsp_sum),   32'd0);
        chk("rst.busy",  32'(busy),      32'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();
        chk("idle.busy", 32'(busy), 32'd0);

        // 2: single op with carry out: F+1 = 10
        grant_op("single", 4'b0001, 16'h000F, 16'h0001, 0);
        chk("single.sum_const", 32'(rsp_sum), 32'h10);
        req_valid = '0;
        release_op("single", 5'h10);

        // requester drops valid before the edge: nothing accepted
        req_valid = 4'b0010;
        #1;
        req_valid = '0;
        tick();
        chk("drop.busy", 32'(busy), 32'd0);
        chk("drop.rspv", 32'(rsp_valid), 32'd0);

        // 3: round-robin from reset with all valid held and rsp_ready high
        do_reset();
        rsp_ready = 1'b1;
        va = 16'h4321;
        vb = 16'h8888;
`ifdef ADD_SCHED_PRIO_EN
        grant_op("rr0", 4'b1111, va, vb, 0); rsp_ready = 1'b1; tick();
        grant_op("rr1", 4'b1111, va, vb, 0); rsp_ready = 1'b1; tick();
        grant_op("rr2", 4'b1111, va, vb, 0); rsp_ready = 1'b1; tick();
        grant_op("rr3", 4'b1111, va, vb, 0); rsp_ready = 1'b1; tick();
        grant_op("rr4", 4'b1111, va, vb, 0); rsp_ready = 1'b1; tick();
`else
        grant_op("rr0", 4'b1111, va, vb, 0); rsp_ready = 1'b1; tick();
        grant_op("rr1", 4'b1111, va, vb, 1); rsp_ready = 1'b1; tick();
        grant_op("rr2", 4'b1111, va, vb, 2); rsp_ready = 1'b1; tick();
        grant_op("rr3", 4'b1111, va, vb, 3); rsp_ready = 1'b1; tick();
        grant_op("rr4", 4'b1111, va, vb, 0); rsp_ready = 1'b1; tick();
`endif
        chk("rr.idle", 32'(busy), 32'd0);
        rsp_ready = 1'b0;

        // sparse mask: after grant 0, mask 0101 -> 2, then wraps to 0
`ifdef ADD_SCHED_PRIO_EN
        grant_op("sp0", 4'b0101, 16'h0A0B, 16'h0706, 0);
        release_op("sp0", 5'h11);
        grant_op("sp1", 4'b0101, 16'h0A0B, 16'h0706, 0);
        release_op("sp1", 5'h11);
`else
        grant_op("sp0", 4'b0101, 16'h0A0B, 16'h0706, 2);
        release_op("sp0", 5'h11);
        grant_op("sp1", 4'b0101, 16'h0A0B, 16'h0706, 0);
        release_op("sp1", 5'h11);
`endif

        // 4: backpressure for 10 cycles with all requesters valid
        grant_op("bp", 4'b1000, 16'h9000, 16'h9000, 3);
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp.rspv",  32'(rsp_valid), 32'd1);
            chk("bp.sum",   32'(rsp_sum),   32'h12);
            chk("bp.id",    32'(rsp_id),    32'd3);
            chk("bp.ready", 32'(req_ready), 32'd0);
        end
        // release and new valid together: release only
        rsp_ready = 1'b1;
        #1;
        chk("bp.rel_ready", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        chk("bp.rel_rspv", 32'(rsp_valid), 32'd0);
        chk("bp.rel_sum",  32'(rsp_sum),   32'h12);
        // grant follows in the first IDLE cycle; last grant was 3 -> 0
        grant_op("bp.next", 4'b1111, 16'h0005, 16'h0006, 0);
        req_valid = '0;
        release_op("bp.next", 5'h0B);

        // 5: exhaustive operands on every requester
        for (int unsigned r = 0; r < NREQ; r++) begin
            for (int unsigned a = 0; a < 16; a++) begin
                for (int unsigned b = 0; b < 16; b++) begin
                    va = '0;
                    vb = '0;
                    va[r*4 +: 4] = 4'(a);
                    vb[r*4 +: 4] = 4'(b);
                    s = 5'(a + b);
                    grant_op("exh", 4'(4'b0001 << r), va, vb, r);
                    req_valid = '0;
                    release_op("exh", s);
                end
            end
        end

        // 6: reset while holding a result
        grant_op("rh", 4'b0100, 16'h0E00, 16'h0300, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rh.rspv", 32'(rsp_valid), 32'd0);
        chk("rh.busy", 32'(busy),      32'd0);
        chk("rh.sum",  32'(rsp_sum),   32'd0);
        grant_op("rh.next", 4'b1111, 16'h2222, 16'h1111, 0);
        req_valid = '0;
        release_op("rh.next", 5'h03);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "timeout");
    end

endmodule
